base5_count_ctrl: RTL

Run/hold/stop sequencer for the modulo-5 digit datapath. Each digit sums its value with an increment, detects Sum == 5, and forces the digit back to 0 with a carry into the next digit.
This block owns that sequencing. It paces increments with a prescaler, cascades carries across DIGITS base-5 digits, compares the count against a programmed target, and reports completion to the top-level FSM and display logic.

---
 rtl/base5_count_ctrl.sv | 125 ++++++++++++
 1 files changed

// File: rtl/base5_count_ctrl.sv
// Run/hold/stop sequencer for a cascade of base-5 digits: prescaled increments,
// ripple carry across digits, terminal-count compare and one-cycle status pulses.
//
// state | meaning
// ------+-----------------------------------------------------------
// IDLE  | count zeroed or untouched, waiting for a valid start
// RUN   | prescaler advancing, count steps once per TICK_DIV cycles
// HOLD  | prescaler and count frozen, waiting for start to resume
// DONE  | count reached latched target, holds until restart or clear
module base5_count_ctrl #(
  parameter int DIGITS   = 2,
  parameter int TICK_DIV = 4
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic                  start,
  input  logic                  stop,
  input  logic                  clear,
  input  logic [3*DIGITS-1:0]   target,
  output logic [3*DIGITS-1:0]   count,
  output logic                  busy,
  output logic                  done,
  output logic                  wrap,
  output logic                  err,
  output logic [1:0]            state
);

  typedef enum logic [1:0] {
    S_IDLE = 2'b00,
    S_RUN  = 2'b01,
    S_HOLD = 2'b10,
    S_DONE = 2'b11
  } state_t;

  localparam int PW = (TICK_DIV > 1) ? $clog2(TICK_DIV) : 1;
  localparam logic [PW-1:0] PRE_LAST = PW'(TICK_DIV - 1);

  state_t                st_q;
  logic [PW-1:0]         pre_q;
  logic [3*DIGITS-1:0]   tgt_q;
  logic [3*DIGITS-1:0]   cnt_inc;
  logic [DIGITS:0]       carry;
  logic [DIGITS-1:0]     digit_ok;
  logic                  tgt_valid;
  logic                  start_go;
  logic                  tick;

  // Ripple the +1 through the digits; a digit sum of 5 folds to 0 and carries.
  assign carry[0] = 1'b1;
  for (genvar i = 0; i < DIGITS; i++) begin : g_dig
    logic [2:0] sum;
    logic       roll;
    assign sum      = count[3*i +: 3] + {2'b00, carry[i]};
    assign roll     = (sum == 3'd5);
    assign carry[i+1] = roll;
    assign cnt_inc[3*i +: 3] = roll ? 3'd0 : sum;
    assign digit_ok[i] = (target[3*i +: 3] <= 3'd4);
  end

  assign tgt_valid = &digit_ok;
  assign start_go  = start & ~stop;
  assign tick      = (pre_q == PRE_LAST);
  assign state     = st_q;

  always_ff @(posedge clk) begin
    if (reset) begin
      st_q  <= S_IDLE;
      pre_q <= '0;
      tgt_q <= '0;
      count <= '0;
      busy  <= 1'b0;
      done  <= 1'b0;
      wrap  <= 1'b0;
      err   <= 1'b0;
    end else begin
      done <= 1'b0;
      wrap <= 1'b0;
      err  <= 1'b0;
      if (clear) begin
        st_q  <= S_IDLE;
        pre_q <= '0;
        count <= '0;
        busy  <= 1'b0;
      end else begin
        case (st_q)
          S_IDLE, S_DONE: begin
            if (start_go) begin
              if (tgt_valid) begin
                tgt_q <= target;
                pre_q <= '0;
                count <= '0;
                busy  <= 1'b1;
                st_q  <= S_RUN;
              end else begin
                err <= 1'b1;
              end
            end
          end
          S_RUN: begin
            // stop beats a terminal tick: the pending increment waits for resume
            if (stop) begin
              st_q <= S_HOLD;
            end else if (tick) begin
              pre_q <= '0;
              count <= cnt_inc;
              wrap  <= carry[DIGITS];
              if (cnt_inc == tgt_q) begin
                done <= 1'b1;
                busy <= 1'b0;
                st_q <= S_DONE;
              end
            end else begin
              pre_q <= pre_q + 1'b1;
            end
          end
          S_HOLD: begin
            if (start_go) st_q <= S_RUN;
          end
          default: st_q <= S_IDLE;
        endcase
      end
    end
  end

endmodule
